// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: bundle field
// widths, pack offsets per stage boundary, and the skid-stage state encoding.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_AW     = 5;
  localparam int WB_SEL_W   = 2;
  localparam int ALU_CTRL_W = 4;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // F/D: ctrl {pred_taken}, data {instr, pc, pc4}
  localparam int FD_CTRL_W    = 1;
  localparam int FD_DATA_W    = 3 * XLEN;
  localparam int FD_PC4_LSB   = 0;
  localparam int FD_PC_LSB    = XLEN;
  localparam int FD_INSTR_LSB = 2 * XLEN;

  // D/E: ctrl {we_rf, we_dmem, wb[1:0], alu_ctrl[3:0], alu_src, branch, jump}
  //      data {rd1, rd2, imm, rd, pc, pc4}
  localparam int DE_CTRL_W       = 7 + ALU_CTRL_W;
  localparam int DE_JUMP_LSB     = 0;
  localparam int DE_BRANCH_LSB   = 1;
  localparam int DE_ALU_SRC_LSB  = 2;
  localparam int DE_ALU_CTRL_LSB = 3;
  localparam int DE_WB_LSB       = DE_ALU_CTRL_LSB + ALU_CTRL_W;
  localparam int DE_WE_DMEM_LSB  = DE_WB_LSB + WB_SEL_W;
  localparam int DE_WE_RF_LSB    = DE_WE_DMEM_LSB + 1;
  localparam int DE_DATA_W       = 5 * XLEN + REG_AW;
  localparam int DE_PC4_LSB      = 0;
  localparam int DE_PC_LSB       = XLEN;
  localparam int DE_RD_LSB       = 2 * XLEN;
  localparam int DE_IMM_LSB      = DE_RD_LSB + REG_AW;
  localparam int DE_RD2_LSB      = DE_IMM_LSB + XLEN;
  localparam int DE_RD1_LSB      = DE_RD2_LSB + XLEN;

  // E/M: ctrl {we_rf, we_dmem, wb[1:0]}, data {alu_rsl, imm_extended, wd, rd, pc4}
  localparam int EM_CTRL_W      = 2 + WB_SEL_W;
  localparam int EM_WB_LSB      = 0;
  localparam int EM_WE_DMEM_LSB = WB_SEL_W;
  localparam int EM_WE_RF_LSB   = WB_SEL_W + 1;
  localparam int EM_DATA_W      = 4 * XLEN + REG_AW;
  localparam int EM_PC4_LSB     = 0;
  localparam int EM_RD_LSB      = XLEN;
  localparam int EM_WD_LSB      = EM_RD_LSB + REG_AW;
  localparam int EM_IMM_LSB     = EM_WD_LSB + XLEN;
  localparam int EM_ALU_LSB     = EM_IMM_LSB + XLEN;

  // M/W: ctrl {we_rf, wb[1:0]}, data {alu_rsl, rdata, imm_extended, rd, pc4}
  localparam int MW_CTRL_W    = 1 + WB_SEL_W;
  localparam int MW_WB_LSB    = 0;
  localparam int MW_WE_RF_LSB = WB_SEL_W;
  localparam int MW_DATA_W    = 4 * XLEN + REG_AW;
  localparam int MW_PC4_LSB   = 0;
  localparam int MW_RD_LSB    = XLEN;
  localparam int MW_IMM_LSB   = MW_RD_LSB + REG_AW;
  localparam int MW_RDATA_LSB = MW_IMM_LSB + XLEN;
  localparam int MW_ALU_LSB   = MW_RDATA_LSB + XLEN;

  function automatic logic [EM_CTRL_W-1:0] em_ctrl_pack(input logic we_rf,
                                                        input logic we_dmem,
                                                        input logic [WB_SEL_W-1:0] wb);
    return {we_rf, we_dmem, wb};
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with flush, bubble ctrl squashing and an
// optional second (skid) slot that lets in_ready come straight from a flop.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int          CTRL_W = EM_CTRL_W,
  parameter int          DATA_W = EM_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  localparam int NSLOT = (SKID != 0) ? 2 : 1;

  skid_state_e       state_q, state_d;
  logic [CTRL_W-1:0] slot_ctrl_q [NSLOT];
  logic [DATA_W-1:0] slot_data_q [NSLOT];
  logic [NSLOT-1:0]  slot_ld;
  logic              from_skid;
  logic              accept, deliver;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // With one slot, ONE+accept always coincides with deliver, so TWO is unreachable.
  always_comb begin
    state_d   = state_q;
    slot_ld   = '0;
    from_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d    = ST_ONE;
          slot_ld[0] = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          slot_ld[0] = 1'b1;
        end else if (accept) begin
          state_d          = ST_TWO;
          slot_ld[NSLOT-1] = 1'b1;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (deliver) begin
          state_d    = ST_ONE;
          slot_ld[0] = 1'b1;
          from_skid  = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush leaves slot contents alone: out_data is don't-care in a bubble.
    if (flush_i) begin
      state_d = ST_EMPTY;
      slot_ld = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        slot_ctrl_q[gi] <= '0;
        slot_data_q[gi] <= '0;
      end else if (slot_ld[gi]) begin
        if (gi == 0 && from_skid) begin
          slot_ctrl_q[gi] <= slot_ctrl_q[NSLOT-1];
          slot_data_q[gi] <= slot_data_q[NSLOT-1];
        end else begin
          slot_ctrl_q[gi] <= in_ctrl;
          slot_data_q[gi] <= in_data;
        end
      end
    end
  end

  if (SKID != 0) begin : g_rdy_reg
    logic in_ready_q;
    always_ff @(posedge clk) begin
      if (!rst_n) in_ready_q <= 1'b1;
      else        in_ready_q <= (state_d != ST_TWO);
    end
    assign in_ready = in_ready_q;
  end else begin : g_rdy_comb
    assign in_ready = (state_q == ST_EMPTY) || out_ready;
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = slot_ctrl_q[0] & {CTRL_W{out_valid}};
  assign out_data  = slot_data_q[0];
  assign occ       = 2'(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Checks a SKID=1 and a SKID=0 instance side by side against a queue model
// of the stage, with directed scenarios followed by random traffic.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 133;
  localparam int BW     = CTRL_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n, flush_i, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;

  logic              s_in_ready, s_out_valid, r_in_ready, r_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl, r_out_ctrl;
  logic [DATA_W-1:0] s_out_data, r_out_data;
  logic [1:0]        s_occ, r_occ;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .occ(s_occ)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_ctrl(r_out_ctrl),
    .out_data(r_out_data), .occ(r_occ)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;
  bit verbose = 1;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (plain register).
  logic [BW-1:0] q_s[$];
  logic [BW-1:0] q_r[$];
  bit acc_s, dlv_s, acc_r, dlv_r;

  always @(posedge clk) begin
    acc_s = in_valid && (q_s.size() < 2);
    dlv_s = (q_s.size() > 0) && out_ready;
    acc_r = in_valid && ((q_r.size() == 0) || out_ready);
    dlv_r = (q_r.size() > 0) && out_ready;
    if (!rst_n || flush_i) begin
      q_s.delete();
      q_r.delete();
    end else begin
      if (dlv_s) begin
        if (verbose) $display("skid : deliver ctrl=%h data=%h", q_s[0][BW-1:DATA_W], q_s[0][DATA_W-1:0]);
        void'(q_s.pop_front());
      end
      if (dlv_r) begin
        if (verbose) $display("plain: deliver ctrl=%h data=%h", q_r[0][BW-1:DATA_W], q_r[0][DATA_W-1:0]);
        void'(q_r.pop_front());
      end
      if (acc_s) q_s.push_back({in_ctrl, in_data});
      if (acc_r) q_r.push_back({in_ctrl, in_data});
    end
  end

  logic [BW-1:0] front;
  int            sz;

  always @(negedge clk) begin
    if (chk_en) begin
      sz = q_s.size();
      front = (sz != 0) ? q_s[0] : '0;
      chk("skid.occ",       DATA_W'(s_occ),       DATA_W'(sz));
      chk("skid.out_valid", DATA_W'(s_out_valid), DATA_W'(sz != 0));
      chk("skid.in_ready",  DATA_W'(s_in_ready),  DATA_W'(sz < 2));
      chk("skid.out_ctrl",  DATA_W'(s_out_ctrl),  DATA_W'(front[BW-1:DATA_W]));
      if (sz != 0) chk("skid.out_data", s_out_data, front[DATA_W-1:0]);

      sz = q_r.size();
      front = (sz != 0) ? q_r[0] : '0;
      chk("plain.occ",       DATA_W'(r_occ),       DATA_W'(sz));
      chk("plain.out_valid", DATA_W'(r_out_valid), DATA_W'(sz != 0));
      chk("plain.in_ready",  DATA_W'(r_in_ready),  DATA_W'((sz == 0) || out_ready));
      chk("plain.out_ctrl",  DATA_W'(r_out_ctrl),  DATA_W'(front[BW-1:DATA_W]));
      if (sz != 0) chk("plain.out_data", r_out_data, front[DATA_W-1:0]);
    end
  end

  initial begin
    // Reset while an all-ones beat is offered.
    rst_n = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'hF; in_data = '1;
    tick();
    chk_en = 1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst.skid.out_valid", DATA_W'(s_out_valid), '0);
    chk("rst.skid.out_ctrl",  DATA_W'(s_out_ctrl),  '0);
    chk("rst.skid.out_data",  s_out_data,           '0);
    chk("rst.skid.occ",       DATA_W'(s_occ),       '0);
    chk("rst.skid.in_ready",  DATA_W'(s_in_ready),  DATA_W'(1));
    chk("rst.plain.in_ready", DATA_W'(r_in_ready),  DATA_W'(1));
    chk("rst.plain.out_data", r_out_data,           '0);

    // Streaming 1..8 at full rate.
    $display("-- streaming");
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_ctrl = 4'(k); in_data = DATA_W'(k);
      tick();
      chk("stream.out_data", s_out_data, DATA_W'(k));
      chk("stream.in_ready", DATA_W'(s_in_ready), DATA_W'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream.drained", DATA_W'(s_out_valid), '0);

    // Stall with A, B, C offered.
    $display("-- stall/skid");
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 4'h1; in_data = DATA_W'('hA); tick();
    chk("stall.occ1", DATA_W'(s_occ), DATA_W'(1));
    chk("stall.rdy1", DATA_W'(s_in_ready), DATA_W'(1));
    in_ctrl = 4'h2; in_data = DATA_W'('hB); tick();
    chk("stall.occ2", DATA_W'(s_occ), DATA_W'(2));
    chk("stall.rdy_after_B", DATA_W'(s_in_ready), '0);
    in_ctrl = 4'h3; in_data = DATA_W'('hC); tick();
    chk("stall.head_A", s_out_data, DATA_W'('hA));
    out_ready = 1'b1; tick();
    chk("release.head_B", s_out_data, DATA_W'('hB));
    chk("release.occ", DATA_W'(s_occ), DATA_W'(1));
    tick();
    chk("release.head_C", s_out_data, DATA_W'('hC));
    in_valid = 1'b0; tick();
    chk("release.empty", DATA_W'(s_occ), '0);

    // Flush with two held plus an incoming beat.
    $display("-- flush");
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 4'b0111; in_data = DATA_W'('h55); tick();
    in_ctrl = 4'b0110; in_data = DATA_W'('h66); tick();
    chk("flush.pre_occ", DATA_W'(s_occ), DATA_W'(2));
    in_ctrl = 4'b1101; in_data = DATA_W'('h77); flush_i = 1'b1; tick();
    flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush.out_valid", DATA_W'(s_out_valid), '0);
    chk("flush.out_ctrl",  DATA_W'(s_out_ctrl),  '0);
    chk("flush.occ",       DATA_W'(s_occ),       '0);
    chk("flush.in_ready",  DATA_W'(s_in_ready),  DATA_W'(1));
    chk("flush.data_hold", s_out_data,           DATA_W'('h55));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush.no_ghost", DATA_W'(s_out_valid), '0);
    end

    // Plain register backpressure.
    $display("-- plain backpressure");
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'h9; in_data = DATA_W'('h101);
    tick();
    chk("bp.full_data", r_out_data, DATA_W'('h101));
    chk("bp.rdy_low", DATA_W'(r_in_ready), '0);
    out_ready = 1'b1; #1;
    chk("bp.rdy_comb", DATA_W'(r_in_ready), DATA_W'(1));
    in_ctrl = 4'hA; in_data = DATA_W'('h202); tick();
    chk("bp.replaced", r_out_data, DATA_W'('h202));
    chk("bp.valid", DATA_W'(r_out_valid), DATA_W'(1));

    // Reset and flush together mid-stream.
    $display("-- reset+flush");
    out_ready = 1'b0; in_data = DATA_W'('h303); tick();
    rst_n = 1'b0; flush_i = 1'b1; in_data = DATA_W'('h404); tick();
    rst_n = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("rf.skid.out_data",  s_out_data, '0);
    chk("rf.plain.out_data", r_out_data, '0);
    chk("rf.skid.in_ready",  DATA_W'(s_in_ready), DATA_W'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rf.skid.quiet",  DATA_W'(s_out_valid), '0);
      chk("rf.plain.quiet", DATA_W'(r_out_valid), '0);
    end

    // Random traffic against the model.
    $display("-- random traffic");
    verbose = 0;
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      flush_i   = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = 4'($urandom());
      in_data   = rnd_data();
      tick();
    end
    rst_n = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    @(posedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register that carries a control bundle and a datapath bundle from one RISC-V pipeline stage to the next, using a valid/ready handshake. It adds hazard-unit stall and flush support, control-field squashing for bubbles, and an optional 2-entry skid buffer so that ready can be registered. It is the generic replacement for the fixed per-stage registers between F/D, D/E, E/M and M/W.

## Interface
- CTRL_W, default 4: width of the control bundle. The E/M instance packs {write_enable_RF, write_enable_dmem, write_back[1:0]}.
- DATA_W, default 133: width of the datapath bundle. The E/M instance packs {alu_rsl, imm_extended, wd, rd, pc4}.
- SKID, default 1: buffering mode.
  - 0: single register; in_ready is combinational.
  - 1: main register plus skid register; in_ready is registered.
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low (as already decided)
- flush_i  input  1  squash all held and incoming beats (hazard unit, branch mispredict)
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream datapath bundle
- out_valid  output  1  beat present for downstream
- out_ready  input  1  downstream accepts (0 = stall)
- out_ctrl  output  CTRL_W  control bundle; all-zero whenever out_valid=0
- out_data  output  DATA_W  datapath bundle
- occ  output  2  entries held (0..2; never exceeds 1 when SKID=0)

## Operation
- A beat is accepted when in_valid && in_ready; it is delivered when out_valid && out_ready.
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_ctrl=0, out_data=0, occ=0, skid register cleared.
  - in_ready=1 after reset in both modes.
  - Reset has priority over flush and over any handshake.
- Flush (flush_i=1 at a clk edge, rst_n=1):
  - All held entries are discarded; any beat offered in the same cycle is dropped.
  - occ=0, out_valid=0, out_ctrl=0.
  - out_data holds its value, because datapath fields are don't-care in a bubble.
  - in_ready=1 on the next cycle.
- SKID=0:
  - in_ready = !out_valid || out_ready.
  - On acceptance the register loads the input. If the register is delivered with no acceptance, out_valid falls to 0.
- SKID=1 state machine, with out_ready as the stall input:
  - EMPTY:
    - accept → ONE.
  - ONE:
    - accept + deliver → ONE, main register loaded.
    - accept, no deliver → TWO, beat stored in the skid register.
    - deliver only → EMPTY.
    - neither → ONE.
  - TWO (in_ready=0):
    - deliver → ONE; the skid register moves to the main register.
    - otherwise hold.
    - Acceptance is impossible in TWO because in_ready=0.
  - in_ready register = next state != TWO.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush or reset.
- out_ctrl = main control register AND out_valid. A bubble therefore never asserts RF or dmem write enables.

## Timing
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N.
- Throughput: 1 beat per cycle while out_ready=1, in both modes.
- SKID=1:
  - in_ready depends only on flops, with no out_ready → in_ready combinational path.
  - One cycle of out_ready=0 costs no upstream throughput.
- SKID=0: in_ready has a combinational path from out_ready.
- Flush takes effect at the edge where it is sampled. out_valid=0 from the following cycle.
- Inputs sampled while rst_n=0 are ignored.

## Structure
- Shared package `pipe_pkg`:
  - Per-stage control and datapath field widths.
  - Pack/unpack field offsets for the F/D, D/E, E/M and M/W bundles.
  - Defaults for CTRL_W/DATA_W per stage.
  - State encoding EMPTY/ONE/TWO.
- Single module, with no sub-module. The skid slot is a second instance of the same register slice, generated only when SKID=1.

## Test plan
1. Reset: drive in_valid=1, in_ctrl=4'hF and in_data=all-ones during rst_n=0 → out_valid=0, out_ctrl=0, out_data=0, occ=0, in_ready=1 after reset.
2. Streaming: SKID=1, 8 beats with in_data=1..8, out_ready=1 → out_data=1..8 on consecutive cycles starting 1 cycle after the first acceptance, in_ready constant 1.
3. Stall/skid: SKID=1, out_ready=0 for 3 cycles while in_valid=1 with data A, B, C.
   - Required: occ 1→2, in_ready=0 after B.
   - After release: A then B delivered, then C accepted. No loss, no duplicate.
4. Flush with TWO entries held plus an incoming beat having ctrl=4'b1101 → next cycle out_valid=0, out_ctrl=0, occ=0, in_ready=1; the dropped beat never appears.
5. SKID=0 backpressure: out_ready=0 while full → in_ready=0 in the same cycle; raise out_ready → in_ready=1 in the same cycle, and the new beat replaces the delivered one at the next edge.
6. Reset and flush asserted together mid-stream → reset values, and no beat is delivered afterward.
